lbm_sweep_scheduler: RTL and testbench

Top-level sequencer for the lattice-Boltzmann core. It walks every node of the GRID_X×GRID_Y lattice and drives the per-node controller with a node address, coordinates and boundary flags. For each node it runs a start/done handshake. Each timestep is two full sweeps, a COLLIDE sweep then a STREAM sweep, followed by a buffer-swap pulse; this repeats for a host-programmed number of iterations.

---
 rtl/lbm_pkg.sv | 20 ++
 rtl/lbm_grid_counter.sv | 62 ++++++
 rtl/lbm_sweep_scheduler.sv | 142 ++++++++++++++
 tb/tb_lbm_sweep_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbm_pkg.sv
// Shared types and default lattice dimensions for the lattice-Boltzmann sweep control path.
package lbm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SWAP  = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  typedef enum logic {
    PHASE_COLLIDE = 1'b0,
    PHASE_STREAM  = 1'b1
  } phase_t;

  localparam int DEFAULT_GRID_X = 16;
  localparam int DEFAULT_GRID_Y = 16;

endpackage

// File: rtl/lbm_grid_counter.sv
// Row-major x/y/address walker over the lattice; clear has priority over advance.
module lbm_grid_counter
  import lbm_pkg::*;
#(
  parameter int GRID_X        = DEFAULT_GRID_X,
  parameter int GRID_Y        = DEFAULT_GRID_Y,
  parameter int GRID_DIM      = GRID_X * GRID_Y,
  parameter int ADDRESS_WIDTH = $clog2(GRID_DIM),
  parameter int XW            = $clog2(GRID_X),
  parameter int YW            = $clog2(GRID_Y)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     adv_i,
  output logic [XW-1:0]            x_o,
  output logic [YW-1:0]            y_o,
  output logic [ADDRESS_WIDTH-1:0] addr_o,
  output logic                     last_o
);

  logic [XW-1:0]            x_q, x_d;
  logic [YW-1:0]            y_q, y_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clr_i) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (adv_i) begin
      addr_d = addr_q + 1'b1;
      if (x_q == XW'(GRID_X - 1)) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign addr_o = addr_q;
  assign last_o = (addr_q == ADDRESS_WIDTH'(GRID_DIM - 1));

endmodule

// File: rtl/lbm_sweep_scheduler.sv
// Timestep sequencer: COLLIDE sweep, STREAM sweep, buffer swap, repeated num_iters times,
// with a start/done handshake to the per-node controller for every lattice node.
module lbm_sweep_scheduler
  import lbm_pkg::*;
#(
  parameter int GRID_X        = DEFAULT_GRID_X,
  parameter int GRID_Y        = DEFAULT_GRID_Y,
  parameter int GRID_DIM      = GRID_X * GRID_Y,
  parameter int ADDRESS_WIDTH = $clog2(GRID_DIM),
  parameter int ITER_WIDTH    = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       run,
  input  logic                       abort,
  input  logic [ITER_WIDTH-1:0]      num_iters,
  input  logic                       node_done,
  output logic                       node_start,
  output logic [ADDRESS_WIDTH-1:0]   node_addr,
  output logic [$clog2(GRID_X)-1:0]  node_x,
  output logic [$clog2(GRID_Y)-1:0]  node_y,
  output logic                       LID,
  output logic                       BOTTOM_WALL,
  output logic                       LEFT_WALL,
  output logic                       RIGHT_WALL,
  output logic                       phase,
  output logic                       swap_buffers,
  output logic                       busy,
  output logic                       done,
  output logic [ITER_WIDTH-1:0]      iter_count
);

  localparam int XW = $clog2(GRID_X);
  localparam int YW = $clog2(GRID_Y);

  sched_state_t          state_q;
  phase_t                phase_q;
  logic [ITER_WIDTH-1:0] iter_q;
  logic [ITER_WIDTH-1:0] niters_q;
  logic [ITER_WIDTH-1:0] iter_next;

  logic last_node;
  logic abort_go;
  logic accept;
  logic node_ack;
  logic cnt_clr;
  logic cnt_adv;

  assign abort_go  = abort && (state_q != IDLE);
  assign accept    = (state_q == IDLE) && run;
  assign node_ack  = (state_q == WAIT) && node_done;
  assign iter_next = iter_q + 1'b1;

  // Counters restart at every sweep boundary and whenever a run begins or is abandoned.
  assign cnt_adv = !abort_go && node_ack && !last_node;
  assign cnt_clr = abort_go || accept || (state_q == SWAP) ||
                   (node_ack && last_node && (phase_q == PHASE_COLLIDE));

  lbm_grid_counter #(
    .GRID_X        (GRID_X),
    .GRID_Y        (GRID_Y),
    .GRID_DIM      (GRID_DIM),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .XW            (XW),
    .YW            (YW)
  ) u_grid_counter (
    .clk_i  (Clk),
    .rst_ni (Reset),
    .clr_i  (cnt_clr),
    .adv_i  (cnt_adv),
    .x_o    (node_x),
    .y_o    (node_y),
    .addr_o (node_addr),
    .last_o (last_node)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      phase_q  <= PHASE_COLLIDE;
      iter_q   <= '0;
      niters_q <= '0;
    end else if (abort_go) begin
      state_q <= IDLE;
      phase_q <= PHASE_COLLIDE;
      iter_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            niters_q <= num_iters;
            phase_q  <= PHASE_COLLIDE;
            iter_q   <= '0;
            state_q  <= (num_iters == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (node_done) begin
            if (!last_node) begin
              state_q <= ISSUE;
            end else if (phase_q == PHASE_COLLIDE) begin
              phase_q <= PHASE_STREAM;
              state_q <= ISSUE;
            end else begin
              state_q <= SWAP;
            end
          end
        end
        SWAP: begin
          iter_q  <= iter_next;
          phase_q <= PHASE_COLLIDE;
          state_q <= (iter_next == niters_q) ? DONE : ISSUE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign node_start   = (state_q == ISSUE);
  assign swap_buffers = (state_q == SWAP);
  assign done         = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign phase        = phase_q;
  assign iter_count   = iter_q;

  // One-hot boundary class, LID > BOTTOM_WALL > LEFT_WALL > RIGHT_WALL.
  always_comb begin
    LID         = 1'b0;
    BOTTOM_WALL = 1'b0;
    LEFT_WALL   = 1'b0;
    RIGHT_WALL  = 1'b0;
    if (busy) begin
      if (node_y == YW'(GRID_Y - 1))      LID         = 1'b1;
      else if (node_y == '0)              BOTTOM_WALL = 1'b1;
      else if (node_x == '0)              LEFT_WALL   = 1'b1;
      else if (node_x == XW'(GRID_X - 1)) RIGHT_WALL  = 1'b1;
    end
  end

endmodule

// File: tb/tb_lbm_sweep_scheduler.sv
// Bench for lbm_sweep_scheduler on a 4x4 lattice: event-queue reference model plus scenario driver.
module tb_lbm_sweep_scheduler;

  localparam int GX = 4;
  localparam int GY = 4;
  localparam int GD = GX * GY;
  localparam int AW = 4;
  localparam int IW = 16;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic [IW-1:0] num_iters = '0;
  logic          node_done = 1'b0;
  logic          node_start;
  logic [AW-1:0] node_addr;
  logic [1:0]    node_x;
  logic [1:0]    node_y;
  logic          LID, BOTTOM_WALL, LEFT_WALL, RIGHT_WALL;
  logic          phase;
  logic          swap_buffers;
  logic          busy;
  logic          done;
  logic [IW-1:0] iter_count;
  logic [3:0]    flags;

  assign flags = {LID, BOTTOM_WALL, LEFT_WALL, RIGHT_WALL};

  lbm_sweep_scheduler #(
    .GRID_X        (GX),
    .GRID_Y        (GY),
    .GRID_DIM      (GD),
    .ADDRESS_WIDTH (AW),
    .ITER_WIDTH    (IW)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .run          (run),
    .abort        (abort),
    .num_iters    (num_iters),
    .node_done    (node_done),
    .node_start   (node_start),
    .node_addr    (node_addr),
    .node_x       (node_x),
    .node_y       (node_y),
    .LID          (LID),
    .BOTTOM_WALL  (BOTTOM_WALL),
    .LEFT_WALL    (LEFT_WALL),
    .RIGHT_WALL   (RIGHT_WALL),
    .phase        (phase),
    .swap_buffers (swap_buffers),
    .busy         (busy),
    .done         (done),
    .iter_count   (iter_count)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected events of one run: kind 0 = node_start, 1 = swap_buffers, 2 = done.
  typedef struct {
    int kind;
    int addr;
    int ph;
    int it;
  } ev_t;

  ev_t q[$];
  bit  active = 1'b0;
  int  exp_iter = 0;
  int  cyc = 0;
  int  acc_cyc = 0;
  int  starts_cnt = 0;
  int  swaps_cnt = 0;
  int  runlen = -1;
  bit  in_node = 1'b0;
  int  last_addr = 0;
  int  last_ph = 0;
  bit  saw_start = 1'b0;
  int  mode = 0;   // 0: node_done after 0 cycles, 1: random 0-5 with noise, 2: node_done held high
  int  rcnt = 0;
  bit  rpend = 1'b0;

  function automatic logic [3:0] exp_flags(input int a);
    int x, y;
    x = a % GX;
    y = a / GX;
    if (y == GY - 1) return 4'b1000;
    if (y == 0)      return 4'b0100;
    if (x == 0)      return 4'b0010;
    if (x == GX - 1) return 4'b0001;
    return 4'b0000;
  endfunction

  // Model: accept runs, honour aborts, forget everything on reset.
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      q.delete();
      active   = 1'b0;
      exp_iter = 0;
      in_node  = 1'b0;
    end else begin
      cyc++;
      if (active && abort) begin
        q.delete();
        active   = 1'b0;
        exp_iter = 0;
        in_node  = 1'b0;
      end else if (!active && run) begin
        for (int it = 0; it < int'(num_iters); it++) begin
          for (int ph = 0; ph < 2; ph++)
            for (int a = 0; a < GD; a++) q.push_back('{0, a, ph, it});
          q.push_back('{1, 0, 0, it + 1});
        end
        q.push_back('{2, 0, 0, int'(num_iters)});
        active     = 1'b1;
        exp_iter   = 0;
        acc_cyc    = cyc;
        starts_cnt = 0;
        swaps_cnt  = 0;
        runlen     = -1;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge Clk) begin
    int  np;
    ev_t e;
    saw_start = node_start;
    chk("busy", busy, active);
    if (!busy) chk("flags_idle", flags, 0);
    else begin
      chk("addr_xy", node_addr, int'(node_y) * GX + int'(node_x));
      chk("flags_decode", flags, exp_flags(int'(node_addr)));
    end
    if (!active) chk("iter_idle", iter_count, exp_iter);
    np = int'(node_start) + int'(swap_buffers) + int'(done);
    if (np > 1) chk("one_pulse", np, 1);
    if (np > 0) begin
      if (q.size() == 0) chk("unexpected_pulse", np, 0);
      else begin
        e = q.pop_front();
        case (e.kind)
          0: begin
            chk("node_start", node_start, 1);
            chk("node_addr", node_addr, e.addr);
            chk("node_x", node_x, e.addr % GX);
            chk("node_y", node_y, e.addr / GX);
            chk("phase", phase, e.ph);
            case (e.addr)
              0:  chk("flag_x0y0", flags, 4'b0100);
              12: chk("flag_x0y3", flags, 4'b1000);
              15: chk("flag_x3y3", flags, 4'b1000);
              7:  chk("flag_x3y1", flags, 4'b0001);
              5:  chk("flag_x1y1", flags, 4'b0000);
              default: ;
            endcase
            starts_cnt++;
            in_node   = 1'b1;
            last_addr = e.addr;
            last_ph   = e.ph;
          end
          1: begin
            chk("swap_buffers", swap_buffers, 1);
            chk("iter_at_swap", iter_count, e.it - 1);
            swaps_cnt++;
            in_node = 1'b0;
          end
          default: begin
            chk("done", done, 1);
            chk("iter_at_done", iter_count, e.it);
            runlen   = cyc - acc_cyc + 1;
            active   = 1'b0;
            exp_iter = e.it;
            in_node  = 1'b0;
          end
        endcase
      end
    end else if (in_node && active) begin
      chk("addr_hold", node_addr, last_addr);
      chk("phase_hold", phase, last_ph);
    end
  end

  // Per-node controller stand-in.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (!Reset || !busy) rpend = 1'b0;
      if (saw_start && Reset && busy) begin
        rpend = 1'b1;
        rcnt  = (mode == 1) ? int'($urandom_range(0, 5)) : 0;
      end
      if (rpend) begin
        if (rcnt == 0) begin
          node_done = 1'b1;
          rpend     = 1'b0;
        end else begin
          node_done = 1'b0;
          rcnt--;
        end
      end else begin
        node_done = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic start_run(input int n);
    @(posedge Clk);
    #1;
    run       = 1'b1;
    num_iters = IW'(n);
    @(posedge Clk);
    #1;
    run = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (active && k < budget) begin
      @(posedge Clk);
      #2;
      k++;
    end
    chk("run_completes", active, 0);
  endtask

  task automatic find_node(input int addr, input int ph, input int it);
    int k;
    bit found;
    k     = 0;
    found = 1'b0;
    while (!found && k < 5000) begin
      @(negedge Clk);
      k++;
      found = node_start && (int'(node_addr) == addr) && (int'(phase) == ph) &&
              (int'(iter_count) == it);
    end
    chk("target_node_found", found, 1);
  endtask

  initial begin
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_node_start", node_start, 0);
    chk("rst_swap", swap_buffers, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", flags, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_addr", node_addr, 0);
    chk("rst_phase", phase, 0);
    Reset = 1'b1;

    // Single iteration, minimal handshake latency.
    mode = 0;
    start_run(1);
    wait_idle(500);
    chk("s1_starts", starts_cnt, 32);
    chk("s1_swaps", swaps_cnt, 1);
    chk("s1_length", runlen, 66);
    chk("s1_iter", iter_count, 1);

    // Zero iterations.
    start_run(0);
    wait_idle(20);
    chk("zero_starts", starts_cnt, 0);
    chk("zero_swaps", swaps_cnt, 0);
    chk("zero_length", runlen, 1);
    chk("zero_iter", iter_count, 0);

    // Random handshake delay, noisy node_done, and a run request while busy.
    mode = 1;
    start_run(2);
    repeat (10) @(posedge Clk);
    #1;
    run       = 1'b1;
    num_iters = 16'd5;
    @(posedge Clk);
    #1;
    run = 1'b0;
    wait_idle(3000);
    chk("rand_starts", starts_cnt, 64);
    chk("rand_swaps", swaps_cnt, 2);
    chk("rand_iter", iter_count, 2);

    // Abort while idle has no effect.
    mode = 0;
    @(posedge Clk);
    #1;
    abort = 1'b1;
    @(posedge Clk);
    #1;
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_iter", iter_count, 2);

    // node_done held high through ISSUE.
    mode = 2;
    start_run(1);
    wait_idle(500);
    chk("hold_starts", starts_cnt, 32);
    chk("hold_length", runlen, 66);

    // Abort in WAIT at addr 7, STREAM, second of three iterations.
    mode = 1;
    start_run(3);
    find_node(7, 1, 1);
    @(posedge Clk);
    #1;
    abort = 1'b1;
    @(posedge Clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_iter", iter_count, 0);
    chk("abort_done", done, 0);
    chk("abort_addr", node_addr, 0);

    // run and abort together while idle: the run is taken.
    mode = 0;
    @(posedge Clk);
    #1;
    run       = 1'b1;
    abort     = 1'b1;
    num_iters = 16'd1;
    @(posedge Clk);
    #1;
    run   = 1'b0;
    abort = 1'b0;
    chk("run_abort_busy", busy, 1);
    wait_idle(500);
    chk("run_abort_starts", starts_cnt, 32);
    chk("run_abort_length", runlen, 66);

    // Asynchronous reset between edges while at addr 5.
    start_run(1);
    find_node(5, 0, 0);
    #2;
    Reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_node_start", node_start, 0);
    chk("arst_addr", node_addr, 0);
    chk("arst_flags", flags, 0);
    chk("arst_phase", phase, 0);
    chk("arst_iter", iter_count, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    start_run(1);
    wait_idle(500);
    chk("post_rst_starts", starts_cnt, 32);
    chk("post_rst_swaps", swaps_cnt, 1);
    chk("post_rst_length", runlen, 66);
    chk("post_rst_iter", iter_count, 1);

    repeat (3) @(posedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
